board_game_engine: RTL and testbench

BOARD_GAME_ENGINE -- requirements
Module: board_game_engine

---
 rtl/board_game_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_board_game_engine.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_game_engine.sv
// Grid board game engine: cursor, marker placement, 4-cycle win scan.
// Ports: clk/rst_n, btn_l/r/u/d, place, new_game -> board, cursor, player, status.
module board_game_engine #(
    parameter int ROWS        = 5,
    parameter int COLS        = 5,
    parameter int WIN_LEN     = 4,
    parameter int NUM_PLAYERS = 2,
    localparam int CW  = $clog2(NUM_PLAYERS + 1),
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int PW  = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_l,
    input  logic                      btn_r,
    input  logic                      btn_u,
    input  logic                      btn_d,
    input  logic                      place,
    input  logic                      new_game,
    output logic [ROWS*COLS*CW-1:0]   board,
    output logic [RW-1:0]             cursor_row,
    output logic [CLW-1:0]            cursor_col,
    output logic [PW-1:0]             cur_player,
    output logic                      busy,
    output logic                      game_over,
    output logic [CW-1:0]             winner,
    output logic                      game_done,
    output logic                      reject
);

    localparam int NC = ROWS * COLS;
    localparam int MW = $clog2(NC + 1);

    typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cells [ROWS][COLS];
    logic [MW-1:0]   moves;
    logic [1:0]      phase;
    logic [RW-1:0]   pr;
    logic [CLW-1:0]  pc;
    logic [CW-1:0]   pp;
    logic            win_seen;
    logic [PW-1:0]   start_player;

    logic            dir_win;
    logic            win_any;
    logic            accept;
    logic            rej;
    logic            fin;
    logic            move_en;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Off-board positions read as empty, so runs stop at the edges.
    function automatic logic [CW-1:0] cell_at(input int r, input int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS)
            return '0;
        return cells[RW'(r)][CLW'(c)];
    endfunction

    genvar gr, gc;
    generate
        for (gr = 0; gr < ROWS; gr++) begin : g_row
            for (gc = 0; gc < COLS; gc++) begin : g_col
                assign board[(gr*COLS+gc)*CW +: CW] = cells[gr][gc];
            end
        end
    endgenerate

    assign busy    = (state == CHECK);
    assign move_en = $onehot({btn_l, btn_r, btn_u, btn_d})
                     && !place && (state != CHECK);
    assign win_any = win_seen | dir_win;

    // One scan direction per CHECK cycle: run through the placed cell.
    always_comb begin : dir_scan
        int dr;
        int dc;
        int r;
        int c;
        int run;
        logic go_f;
        logic go_b;
        dr = 0;
        dc = 1;
        unique case (phase)
            2'd0: begin dr = 0; dc = 1;  end
            2'd1: begin dr = 1; dc = 0;  end
            2'd2: begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        run  = 1;
        go_f = 1'b1;
        go_b = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            r = int'(pr) + k * dr;
            c = int'(pc) + k * dc;
            if (go_f && cell_at(r, c) == pp) run++;
            else go_f = 1'b0;
            r = int'(pr) - k * dr;
            c = int'(pc) - k * dc;
            if (go_b && cell_at(r, c) == pp) run++;
            else go_b = 1'b0;
        end
        dir_win = (run >= WIN_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PLAY;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        rej     = 1'b0;
        fin     = 1'b0;
        if (new_game) begin
            state_n = PLAY;
        end else begin
            unique case (state)
                PLAY: begin
                    if (place) begin
                        if (cells[cursor_row][cursor_col] == '0) begin
                            accept  = 1'b1;
                            state_n = CHECK;
                        end else begin
                            rej = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    rej = place;
                    if (phase == 2'd3) begin
                        if (win_any || moves == MW'(NC)) begin
                            fin     = 1'b1;
                            state_n = DONE;
                        end else begin
                            state_n = PLAY;
                        end
                    end
                end
                DONE: rej = place;
                default: state_n = PLAY;
            endcase
            // game_done owns the cycle; a colliding reject is dropped.
            if (fin) rej = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= '0;
            moves        <= '0;
            phase        <= '0;
            pr           <= '0;
            pc           <= '0;
            pp           <= '0;
            win_seen     <= 1'b0;
            start_player <= '0;
            cur_player   <= '0;
            cursor_row   <= '0;
            cursor_col   <= '0;
            game_over    <= 1'b0;
            winner       <= '0;
            game_done    <= 1'b0;
            reject       <= 1'b0;
        end else if (new_game) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= '0;
            moves        <= '0;
            phase        <= '0;
            win_seen     <= 1'b0;
            start_player <= nxt(start_player);
            cur_player   <= nxt(start_player);
            cursor_row   <= '0;
            cursor_col   <= '0;
            game_over    <= 1'b0;
            winner       <= '0;
            game_done    <= 1'b0;
            reject       <= 1'b0;
        end else begin
            game_done <= fin;
            reject    <= rej;
            if (accept) begin
                cells[cursor_row][cursor_col] <= CW'(cur_player) + CW'(1);
                moves    <= moves + 1'b1;
                pr       <= cursor_row;
                pc       <= cursor_col;
                pp       <= CW'(cur_player) + CW'(1);
                phase    <= '0;
                win_seen <= 1'b0;
            end
            if (state == CHECK) begin
                phase    <= phase + 1'b1;
                win_seen <= win_any;
                if (phase == 2'd3) begin
                    if (fin) begin
                        game_over <= 1'b1;
                        winner    <= win_any ? pp : '0;
                    end else begin
                        cur_player <= nxt(cur_player);
                    end
                end
            end
            if (move_en) begin
                unique case (1'b1)
                    btn_l: cursor_col <= (cursor_col == '0)
                                         ? CLW'(COLS - 1) : cursor_col - 1'b1;
                    btn_r: cursor_col <= (cursor_col == CLW'(COLS - 1))
                                         ? '0 : cursor_col + 1'b1;
                    btn_u: cursor_row <= (cursor_row == '0)
                                         ? RW'(ROWS - 1) : cursor_row - 1'b1;
                    btn_d: cursor_row <= (cursor_row == RW'(ROWS - 1))
                                         ? '0 : cursor_row + 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_game_engine.sv
// Scoreboard bench for board_game_engine: random games vs a board model.
// Expected reject/game_done events are queued; a monitor pops and compares.
module tb_board_game_engine;

    localparam int ROWS    = 5;
    localparam int COLS    = 5;
    localparam int WIN_LEN = 4;
    localparam int NP      = 2;
    localparam int CW      = 2;
    localparam int BW      = ROWS * COLS * CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic place = 1'b0, new_game = 1'b0;
    logic [BW-1:0] board;
    logic [2:0]    cursor_row, cursor_col;
    logic [0:0]    cur_player;
    logic          busy, game_over, game_done, reject;
    logic [CW-1:0] winner;

    always #5 clk = ~clk;

    board_game_engine #(
        .ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN), .NUM_PLAYERS(NP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .place(place), .new_game(new_game),
        .board(board), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .cur_player(cur_player), .busy(busy), .game_over(game_over),
        .winner(winner), .game_done(game_done), .reject(reject)
    );

    typedef struct {
        bit            is_done;
        int            win;
        logic [BW-1:0] brd;
        int            plr;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    int  mb [ROWS][COLS];
    int  m_row, m_col, m_player, m_start, m_moves;
    bit  m_over;

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [BW-1:0] m_flat();
        logic [BW-1:0] f;
        f = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f[(r*COLS+c)*CW +: CW] = CW'(mb[r][c]);
        return f;
    endfunction

    // Whole-board search for any WIN_LEN straight line of player mark p.
    function automatic bit m_win(input int p);
        int dr, dc, rr, cc;
        bit all;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int d = 0; d < 4; d++) begin
                    dr = (d == 0) ? 0 : 1;
                    dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                    all = 1'b1;
                    for (int k = 0; k < WIN_LEN; k++) begin
                        rr = r + k * dr;
                        cc = c + k * dc;
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
                            all = 1'b0;
                        else if (mb[rr][cc] != p)
                            all = 1'b0;
                    end
                    if (all) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic void push_ev(input bit d, input int w, input int plr);
        ev_t e;
        e.is_done = d;
        e.win     = w;
        e.brd     = m_flat();
        e.plr     = plr;
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = 0;
        m_row   = 0;
        m_col   = 0;
        m_moves = 0;
        m_over  = 1'b0;
    endfunction

    function automatic void model_new();
        model_clear();
        m_start  = (m_start + 1) % NP;
        m_player = m_start;
    endfunction

    task automatic check_fresh(input string nm);
        chk({nm, "_board"}, board, m_flat());
        chk({nm, "_player"}, cur_player, m_player);
        chk({nm, "_row"}, cursor_row, 0);
        chk({nm, "_col"}, cursor_col, 0);
        chk({nm, "_over"}, game_over, 0);
        chk({nm, "_winner"}, winner, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic act(input bit l, input bit r, input bit u, input bit d,
                       input bit p, input bit extra);
        int  ndir, placer, n;
        bit  acc;
        ndir   = int'(l) + int'(r) + int'(u) + int'(d);
        placer = m_player;
        acc    = p && !m_over && (mb[m_row][m_col] == 0);
        if (p && !acc) push_ev(1'b0, 0, m_player);
        if (acc) begin
            mb[m_row][m_col] = placer + 1;
            m_moves++;
            if (extra) push_ev(1'b0, 0, placer);
            if (m_win(placer + 1)) begin
                push_ev(1'b1, placer + 1, placer);
                m_over = 1'b1;
            end else if (m_moves == ROWS * COLS) begin
                push_ev(1'b1, 0, placer);
                m_over = 1'b1;
            end else begin
                m_player = (m_player + 1) % NP;
            end
        end
        if (!p && ndir == 1) begin
            if (l) m_col = (m_col + COLS - 1) % COLS;
            if (r) m_col = (m_col + 1) % COLS;
            if (u) m_row = (m_row + ROWS - 1) % ROWS;
            if (d) m_row = (m_row + 1) % ROWS;
        end
        @(negedge clk);
        btn_l = l; btn_r = r; btn_u = u; btn_d = d; place = p;
        @(negedge clk);
        btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0; place = 0;
        chk("cursor_row", cursor_row, m_row);
        chk("cursor_col", cursor_col, m_col);
        if (acc) begin
            n = 0;
            while (busy && n < 10) begin
                place = extra && (n == 1);
                @(negedge clk);
                n++;
            end
            place = 0;
            chk("busy_cycles", n, 4);
        end else begin
            chk("busy_idle", busy, 0);
        end
    endtask

    task automatic goto_cell(input int tr, input int tc);
        bit dir;
        int g;
        dir = 1'($urandom % 2);
        g = 0;
        while (m_col != tc && g < 20) begin
            if (dir) act(0, 1, 0, 0, 0, 0);
            else     act(1, 0, 0, 0, 0, 0);
            g++;
        end
        g = 0;
        while (m_row != tr && g < 20) begin
            if (dir) act(0, 0, 0, 1, 0, 0);
            else     act(0, 0, 1, 0, 0, 0);
            g++;
        end
    endtask

    task automatic play(input int tr, input int tc, input bit extra);
        goto_cell(tr, tc);
        act(0, 0, 0, 0, 1, extra);
    endtask

    task automatic newg();
        @(negedge clk);
        new_game = 1;
        place = 1'($urandom % 2);
        btn_r = 1'($urandom % 2);
        @(negedge clk);
        new_game = 0; place = 0; btn_r = 0;
        model_new();
        check_fresh("new_game");
    endtask

    // Monitor: every reject/game_done pulse must match the queue head.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (reject || game_done)) begin
                chk("rej_done_excl", reject & game_done, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: reject=%0b game_done=%0b expected none",
                             reject, game_done);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", game_done, e.is_done);
                    chk("event_board", board, e.brd);
                    chk("event_player", cur_player, e.plr);
                    if (game_done) begin
                        chk("winner", winner, e.win);
                        chk("game_over", game_over, 1);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int al_r[$], al_c[$], bl_r[$], bl_c[$];
        int tr, tc, guard;
        m_start  = 0;
        m_player = 0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_board", board, 0);
        chk("rst_player", cur_player, 0);
        chk("rst_row", cursor_row, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_status", {busy, game_over, game_done, reject, winner}, 0);
        rst_n = 1;
        @(negedge clk);

        act(1, 0, 0, 0, 0, 0);
        chk("wrap_left_col", cursor_col, 4);
        chk("wrap_left_row", cursor_row, 0);
        act(0, 0, 1, 0, 0, 0);
        chk("wrap_up_row", cursor_row, 4);
        act(1, 1, 0, 0, 0, 0);
        act(0, 1, 0, 1, 0, 0);
        goto_cell(0, 0);

        goto_cell(2, 2);
        @(negedge clk);
        place = 1;
        @(negedge clk);
        place = 0;
        chk("abort_busy", busy, 1);
        new_game = 1;
        @(negedge clk);
        new_game = 0;
        model_new();
        check_fresh("abort");
        chk("second_game_player", cur_player, 1);
        repeat (8) @(negedge clk);
        newg();
        chk("third_game_player", cur_player, 0);

        play(0, 0, 0);
        play(0, 0, 0);
        chk("reject_keeps_player", cur_player, 1);
        play(1, 0, 1);
        play(0, 1, 0);
        play(1, 1, 0);
        goto_cell(0, 2);
        act(0, 1, 0, 0, 1, 0);
        play(1, 2, 0);
        play(0, 3, 0);
        act(0, 0, 0, 0, 1, 0);
        act(1, 0, 0, 0, 0, 0);
        newg();

        play(0, 2, 0); play(4, 4, 0);
        play(1, 1, 0); play(4, 1, 0);
        play(2, 0, 0); play(2, 3, 0);
        play(0, 3, 0); play(3, 4, 0);
        play(1, 2, 0); play(4, 3, 0);
        play(2, 1, 0); play(1, 4, 0);
        play(3, 0, 0);
        newg();

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (((c / 2) + r) % 2 == 0) begin
                    al_r.push_back(r); al_c.push_back(c);
                end else begin
                    bl_r.push_back(r); bl_c.push_back(c);
                end
        for (int i = 0; i < al_r.size(); i++) begin
            play(al_r[i], al_c[i], 0);
            if (i < bl_r.size()) play(bl_r[i], bl_c[i], 0);
        end
        act(0, 0, 0, 0, 1, 0);
        newg();

        for (int g = 0; g < 20; g++) begin
            guard = 0;
            while (!m_over && guard < 80) begin
                tr = int'($urandom % ROWS);
                tc = int'($urandom % COLS);
                if (mb[tr][tc] != 0 && ($urandom % 4 != 0)) begin
                    for (int k = 0; k < ROWS * COLS; k++)
                        if (mb[k / COLS][k % COLS] == 0) begin
                            tr = k / COLS;
                            tc = k % COLS;
                        end
                end
                if ($urandom % 8 == 0) act(1, 0, 1, 0, 0, 0);
                play(tr, tc, ($urandom % 6) == 0);
                guard++;
            end
            if ($urandom % 2 == 1) act(0, 0, 0, 0, 1, 0);
            newg();
        end

        goto_cell(1, 1);
        @(negedge clk);
        place = 1;
        @(negedge clk);
        place = 0;
        chk("midcheck_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_board", board, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1;
        m_start  = 0;
        m_player = 0;
        model_clear();
        repeat (8) @(negedge clk);
        check_fresh("after_rst");

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
